// File: rtl/alu_issue_queue.sv
// alu_issue_queue: FIFO front-end for a combinational ALU.
// Commands {op, a, b} queue in a DEPTH-entry buffer. The head entry drives the ALU,
// and the ALU result is captured into an output register behind a valid/ready handshake.
module alu_issue_queue #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_op,
  input  logic [W-1:0]             in_a,
  input  logic [W-1:0]             in_b,
  output logic [2:0]               alu_op,
  output logic [W-1:0]             alu_a,
  output logic [W-1:0]             alu_b,
  input  logic [W-1:0]             alu_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2:0]               out_op,
  output logic [W-1:0]             out_result,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Storage is read asynchronously because the head entry must reach the ALU
  // in the same cycle it becomes the head.
  logic [2:0]   op_mem [DEPTH];
  logic [W-1:0] a_mem  [DEPTH];
  logic [W-1:0] b_mem  [DEPTH];

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          out_valid_reg, out_valid_next;
  logic [2:0]    out_op_reg, out_op_next;
  logic [W-1:0]  out_result_reg, out_result_next;

  logic nonempty;
  logic push;
  logic issue;

  assign nonempty = (count_reg != '0);
  // A full queue does not accept input even when it issues in the same cycle.
  assign in_ready = (count_reg != FULL);
  // Flush suppresses both the write and the capture for its cycle.
  assign push     = in_valid && in_ready && !flush;
  assign issue    = nonempty && (!out_valid_reg || out_ready) && !flush;

  assign alu_op = nonempty ? op_mem[rd_ptr_reg] : 3'd0;
  assign alu_a  = nonempty ? a_mem[rd_ptr_reg]  : '0;
  assign alu_b  = nonempty ? b_mem[rd_ptr_reg]  : '0;

  assign out_valid  = out_valid_reg;
  assign out_op     = out_op_reg;
  assign out_result = out_result_reg;
  assign count      = count_reg;

  // Write accepted commands into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr_reg] <= in_op;
      a_mem[wr_ptr_reg]  <= in_a;
      b_mem[wr_ptr_reg]  <= in_b;
    end
  end

  // Next-state for the pointers, the occupancy and the output register.
  always_comb begin
    wr_ptr_next     = wr_ptr_reg;
    rd_ptr_next     = rd_ptr_reg;
    count_next      = count_reg;
    out_valid_next  = out_valid_reg;
    out_op_next     = out_op_reg;
    out_result_next = out_result_reg;

    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push)  wr_ptr_next = wr_ptr_reg + AW'(1);
      if (issue) rd_ptr_next = rd_ptr_reg + AW'(1);
      case ({push, issue})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end

    // Without an issue the output register can only drain; data bits are held.
    if (issue) begin
      out_valid_next  = 1'b1;
      out_result_next = alu_result;
      out_op_next     = op_mem[rd_ptr_reg];
    end else if (out_ready) begin
      out_valid_next  = 1'b0;
    end
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      out_valid_reg  <= 1'b0;
      out_op_reg     <= 3'd0;
      out_result_reg <= '0;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      count_reg      <= count_next;
      out_valid_reg  <= out_valid_next;
      out_op_reg     <= out_op_next;
      out_result_reg <= out_result_next;
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed testbench for alu_issue_queue; the ALU is modelled as alu_a + alu_b.
module tb_alu_issue_queue;
  localparam int W = 8;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   in_op = 3'd0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_result;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [2:0]   out_op;
  logic [W-1:0] out_result;
  logic [2:0]   count;

  int tests_run = 0;
  int fail_count = 0;

  assign alu_result = alu_a + alu_b;

  always #5 clk = ~clk;

  alu_issue_queue #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_result(out_result),
    .count(count)
  );

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++; if (in_ready !== 1'b1) begin fail_count++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    tests_run++; if (count !== 3'd0) begin fail_count++; $display("FAIL reset_count got=%0d exp=0", count); end
    tests_run++; if (out_valid !== 1'b0) begin fail_count++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    tests_run++; if (out_result !== 8'd0 || out_op !== 3'd0) begin fail_count++; $display("FAIL reset_out_data got=%0d/%0d exp=0/0", out_result, out_op); end
    tests_run++; if ({alu_op, alu_a, alu_b} !== 19'd0) begin fail_count++; $display("FAIL reset_alu got=%0d/%0d/%0d exp=0/0/0", alu_op, alu_a, alu_b); end
    rst = 1'b0;
    $display("[TB] reset done");
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = 3'd0; in_a = 8'd4; in_b = 8'd4;
    @(negedge clk);
    in_valid = 1'b0;
    tests_run++; if (alu_a !== 8'd4 || alu_b !== 8'd4) begin fail_count++; $display("FAIL single_alu got=%0d/%0d exp=4/4", alu_a, alu_b); end
    tests_run++; if (count !== 3'd1 || out_valid !== 1'b0) begin fail_count++; $display("FAIL single_after_accept got count=%0d ov=%0b exp 1/0", count, out_valid); end
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b1 || out_result !== 8'd8 || out_op !== 3'd0) begin fail_count++; $display("FAIL single_result got ov=%0b res=%0d op=%0d exp 1/8/0", out_valid, out_result, out_op); end
    tests_run++; if (count !== 3'd0) begin fail_count++; $display("FAIL single_count got=%0d exp=0", count); end
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b0 || out_result !== 8'd8) begin fail_count++; $display("FAIL single_drain got ov=%0b res=%0d exp 0/8", out_valid, out_result); end
    $display("[TB] single command 4+4 -> %0d", out_result);
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1; in_op = 3'(i); in_a = 8'(i); in_b = 8'd0;
      @(negedge clk);
    end
    tests_run++; if (count !== 3'd4 || in_ready !== 1'b0) begin fail_count++; $display("FAIL fill_full got count=%0d rdy=%0b exp 4/0", count, in_ready); end
    tests_run++; if (out_valid !== 1'b1 || out_result !== 8'd1) begin fail_count++; $display("FAIL fill_head got ov=%0b res=%0d exp 1/1", out_valid, out_result); end
    in_a = 8'd6; in_op = 3'd6;
    @(negedge clk);
    in_valid = 1'b0;
    tests_run++; if (count !== 3'd4 || out_result !== 8'd1) begin fail_count++; $display("FAIL fill_blocked got count=%0d res=%0d exp 4/1", count, out_result); end
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tests_run++; if (out_valid !== 1'b1 || out_result !== 8'(i) || out_op !== 3'(i)) begin fail_count++; $display("FAIL fill_order[%0d] got ov=%0b res=%0d op=%0d exp 1/%0d/%0d", i, out_valid, out_result, out_op, i, i); end
      $display("[TB] fill drain result %0d", out_result);
      @(negedge clk);
    end
    tests_run++; if (out_valid !== 1'b0 || count !== 3'd0) begin fail_count++; $display("FAIL fill_empty got ov=%0b count=%0d exp 0/0", out_valid, count); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      if (n < 10) begin
        in_valid = 1'b1; in_op = 3'((n + 1) % 8); in_a = 8'(n + 1); in_b = 8'(n + 1);
        tests_run++; if (in_ready !== 1'b1) begin fail_count++; $display("FAIL stream_ready[%0d] got=%0b exp=1", n, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
      if (n >= 2) begin
        tests_run++;
        if (out_valid !== 1'b1 || out_result !== 8'(2 * (n - 1)) || out_op !== 3'((n - 1) % 8)) begin
          fail_count++;
          $display("FAIL stream_out[%0d] got ov=%0b res=%0d op=%0d exp 1/%0d/%0d", n - 2, out_valid, out_result, out_op, 2 * (n - 1), (n - 1) % 8);
        end
        $display("[TB] stream result %0d op %0d", out_result, out_op);
      end
      @(negedge clk);
    end
    tests_run++; if (out_valid !== 1'b0 || count !== 3'd0) begin fail_count++; $display("FAIL stream_end got ov=%0b count=%0d exp 0/0", out_valid, count); end
  endtask

  task automatic test_push_issue();
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_op = 3'd1; in_a = 8'(10 * i); in_b = 8'd1;
      @(negedge clk);
    end
    tests_run++; if (count !== 3'd2 || out_result !== 8'd11) begin fail_count++; $display("FAIL pi_setup got count=%0d res=%0d exp 2/11", count, out_result); end
    in_a = 8'd40; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    tests_run++; if (count !== 3'd2 || out_result !== 8'd21) begin fail_count++; $display("FAIL pi_simul got count=%0d res=%0d exp 2/21", count, out_result); end
    @(negedge clk);
    tests_run++; if (count !== 3'd1 || out_result !== 8'd31) begin fail_count++; $display("FAIL pi_third got count=%0d res=%0d exp 1/31", count, out_result); end
    @(negedge clk);
    tests_run++; if (count !== 3'd0 || out_result !== 8'd41 || out_valid !== 1'b1) begin fail_count++; $display("FAIL pi_fourth got count=%0d res=%0d ov=%0b exp 0/41/1", count, out_result, out_valid); end
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b0) begin fail_count++; $display("FAIL pi_drain got ov=%0b exp 0", out_valid); end
    $display("[TB] push+issue at count 2 done");
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_op = 3'd2; in_a = 8'(i); in_b = 8'd0;
      @(negedge clk);
    end
    tests_run++; if (count !== 3'd3 || out_valid !== 1'b1) begin fail_count++; $display("FAIL flush_setup got count=%0d ov=%0b exp 3/1", count, out_valid); end
    flush = 1'b1; in_a = 8'd9; in_b = 8'd9;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    tests_run++; if (count !== 3'd0 || {alu_op, alu_a, alu_b} !== 19'd0) begin fail_count++; $display("FAIL flush_clear got count=%0d alu=%0d/%0d/%0d exp 0/0/0/0", count, alu_op, alu_a, alu_b); end
    tests_run++; if (out_valid !== 1'b1 || out_result !== 8'd1 || out_op !== 3'd2) begin fail_count++; $display("FAIL flush_out_kept got ov=%0b res=%0d op=%0d exp 1/1/2", out_valid, out_result, out_op); end
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b1 || count !== 3'd0) begin fail_count++; $display("FAIL flush_hold got ov=%0b count=%0d exp 1/0", out_valid, count); end
    out_ready = 1'b1;
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b0 || count !== 3'd0 || out_result !== 8'd1) begin fail_count++; $display("FAIL flush_drain got ov=%0b count=%0d res=%0d exp 0/0/1", out_valid, count, out_result); end
    $display("[TB] flush done");
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_op = 3'd3; in_a = 8'(20 + i); in_b = 8'd0;
      @(negedge clk);
    end
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++; if (out_valid !== 1'b0 || out_result !== 8'd0 || out_op !== 3'd0) begin fail_count++; $display("FAIL rstmid_out got ov=%0b res=%0d op=%0d exp 0/0/0", out_valid, out_result, out_op); end
    tests_run++; if (count !== 3'd0 || in_ready !== 1'b1) begin fail_count++; $display("FAIL rstmid_queue got count=%0d rdy=%0b exp 0/1", count, in_ready); end
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = 3'd5; in_a = 8'd7; in_b = 8'd3;
    @(negedge clk);
    in_valid = 1'b0;
    tests_run++; if (alu_a !== 8'd7 || alu_op !== 3'd5 || out_valid !== 1'b0) begin fail_count++; $display("FAIL rstmid_accept got a=%0d op=%0d ov=%0b exp 7/5/0", alu_a, alu_op, out_valid); end
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b1 || out_result !== 8'd10 || out_op !== 3'd5) begin fail_count++; $display("FAIL rstmid_result got ov=%0b res=%0d op=%0d exp 1/10/5", out_valid, out_result, out_op); end
    $display("[TB] reset mid-operation done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_push_issue();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
